cpu_bus_responder: RTL and testbench
====================================

CPU_BUS_RESPONDER -- requirements
Module: cpu_bus_responder

Interface
REQ-001 Parameter RAM_AW, default 11, internal RAM address width (2 KiB), mirrored across $0000-$1FFF.
REQ-002 Parameter PAD1_ADDR, default 16'h4016, controller port 1 data/strobe register address.
REQ-003 Parameter PAD2_ADDR, default 16'h4017, controller port 2 data register address.
REQ-004 Port clk  input  1  single system clock; all state changes on its rising edge.
REQ-005 Port rst  input  1  asynchronous, active-low reset (rst=0 resets immediately, regardless of clk).
REQ-006 Port addr  input  16  CPU address.
REQ-007 Port d_out  input  8  CPU write data.
REQ-008 Port write  input  1  CPU write enable; 1=write, 0=read.
REQ-009 Port d_in  output  8  registered read data returned to the CPU.
REQ-010 Port pad1_buttons  input  8  live button states, port 1 (bit0=A ... bit7=Right), 1=pressed.
REQ-011 Port pad2_buttons  input  8  live button states, port 2.
REQ-012 Port rom_addr  output  15  PRG ROM address, combinationally equal to addr[14:0].
REQ-013 Port rom_data  input  8  PRG ROM data, valid in the same cycle as rom_addr.

Function
REQ-014 Address decode: $0000-$1FFF RAM (index addr[RAM_AW-1:0]); PAD1_ADDR; PAD2_ADDR; $8000-$FFFF ROM; every other address unmapped.
REQ-015 d_in is a register loaded on every rising edge; read latency is exactly one cycle from addr presentation.
REQ-016 Read, RAM: d_in <= ram[addr[RAM_AW-1:0]] (synchronous read).
REQ-017 Read, ROM: d_in <= rom_data.
REQ-018 Read, unmapped: d_in holds its previous value (open bus).
REQ-019 Read, PADn: d_in <= {7'b0100000, shn[0]}, where shn is the port's 8-bit shift register.
REQ-020 Write cycle (write=1), any address: d_in <= d_out, modelling the bus carrying the written data.
REQ-021 Write, RAM: ram[addr[RAM_AW-1:0]] <= d_out on that edge.
REQ-022 Write, PAD1_ADDR: strobe <= d_out[0]; bits 7:1 are ignored.
REQ-023 Writes to ROM, PAD2_ADDR and unmapped addresses change no state other than d_in.
REQ-024 Read during write: the same-edge RAM read returns the old contents; the write takes effect for the next access.
REQ-025 Access edge detect: prev_addr/prev_write registers capture addr/write every cycle.
REQ-026 A PADn read "access" occurs only on the first cycle of a run where addr==PADn, write=0 and (prev_addr!=PADn or prev_write=1); a held address counts once.
REQ-027 Per-port controller FSM has two states, LOAD and SHIFT.
REQ-028 LOAD (strobe=1): shn <= padn_buttons every cycle; reads return the live bit0; no shifting.
REQ-029 LOAD->SHIFT on the edge where strobe goes 1->0; shn holds the last sample.
REQ-030 SHIFT: each PADn access returns shn[0], then shn <= {1'b1, shn[7:1]}; after 8 accesses, reads return 1.
REQ-031 SHIFT->LOAD on the edge where strobe is written to 1; strobe applies to both ports.
REQ-032 Simultaneous events: a PAD1_ADDR write takes priority; no PAD1 access counts on a write cycle.

Reset
REQ-033 While rst=0: d_in=8'h00, strobe=0, both FSMs in SHIFT, sh1=sh2=8'hFF, prev_addr=16'h0000, prev_write=1.
REQ-034 RAM contents are not reset.
REQ-035 Reset asserted mid-shift discards any partial shift; the first PAD read after release returns 8'h41.

Verification
REQ-036 Write $0005=A5, then read $0805: d_in=A5 one cycle after the read address is presented.
REQ-037 pad1=8'b1000_0001; write $4016=01, then 00; nine $4016 reads separated by $0000 reads: 41, 40x6, 41, 41.
REQ-038 $4016 read held for 3 cycles in SHIFT: one shift occurs; the next separate access returns the next bit.
REQ-039 Read $8123 with rom_data=5A: rom_addr=15'h0123 and d_in=5A next cycle; writing 00 to $8123 leaves the ROM read unchanged.
REQ-040 Read $0010 returning 3C, then read $5000: d_in stays 3C.
REQ-041 Assert rst mid-shift with strobe=1: d_in=00 immediately and strobe=0; after release, a $4016 read returns 41.

Source files
------------

// File: rtl/cpu_bus_responder.sv
// CPU-side bus responder: mirrored RAM, two serial controller ports, PRG ROM.
// Ports: clk, rst (async active-low), addr/d_out/write in, d_in out, pad buttons, rom_addr/rom_data.
module cpu_bus_responder #(
  parameter int          RAM_AW    = 11,
  parameter logic [15:0] PAD1_ADDR = 16'h4016,
  parameter logic [15:0] PAD2_ADDR = 16'h4017
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr,
  input  logic [7:0]  d_out,
  input  logic        write,
  output logic [7:0]  d_in,
  input  logic [7:0]  pad1_buttons,
  input  logic [7:0]  pad2_buttons,
  output logic [14:0] rom_addr,
  input  logic [7:0]  rom_data
);

  typedef enum logic {
    LOAD,
    SHIFT
  } pad_state_t;

  logic [7:0] ram [0:(1<<RAM_AW)-1];

  logic [RAM_AW-1:0] ram_idx;
  logic              is_ram;
  logic              is_pad1;
  logic              is_pad2;
  logic              is_rom;

  logic [15:0] prev_addr;
  logic        prev_write;
  logic        strobe;

  pad_state_t  state1;
  pad_state_t  state2;
  logic [7:0]  sh1;
  logic [7:0]  sh2;

  logic        acc1;
  logic        acc2;
  logic        pad1_wr;
  logic        strobe_set;
  logic        strobe_clr;
  logic        bit1;
  logic        bit2;

  assign rom_addr = addr[14:0];
  assign ram_idx  = addr[RAM_AW-1:0];

  assign is_ram  = (addr[15:13] == 3'b000);
  assign is_pad1 = (addr == PAD1_ADDR);
  assign is_pad2 = (addr == PAD2_ADDR);
  assign is_rom  = addr[15];

  // An access is the first read cycle of a run on the port address.
  assign acc1 = is_pad1 && !write &&
                ((prev_addr != PAD1_ADDR) || prev_write);
  assign acc2 = is_pad2 && !write &&
                ((prev_addr != PAD2_ADDR) || prev_write);

  assign pad1_wr    = write && is_pad1;
  assign strobe_set = pad1_wr && d_out[0];
  assign strobe_clr = pad1_wr && !d_out[0];

  // While loading, reads see the live button rather than the latch.
  assign bit1 = (state1 == LOAD) ? pad1_buttons[0] : sh1[0];
  assign bit2 = (state2 == LOAD) ? pad2_buttons[0] : sh2[0];

  // RAM is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (write && is_ram) begin
      ram[ram_idx] <= d_out;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d_in       <= 8'h00;
      strobe     <= 1'b0;
      state1     <= SHIFT;
      state2     <= SHIFT;
      sh1        <= 8'hFF;
      sh2        <= 8'hFF;
      prev_addr  <= 16'h0000;
      prev_write <= 1'b1;
    end else begin
      prev_addr  <= addr;
      prev_write <= write;

      // Unmapped reads leave d_in alone (open bus).
      if (write) begin
        d_in <= d_out;
      end else if (is_ram) begin
        d_in <= ram[ram_idx];
      end else if (is_pad1) begin
        d_in <= {7'b0100000, bit1};
      end else if (is_pad2) begin
        d_in <= {7'b0100000, bit2};
      end else if (is_rom) begin
        d_in <= rom_data;
      end

      if (pad1_wr) begin
        strobe <= d_out[0];
      end

      unique case (state1)
        LOAD: begin
          if (strobe_clr) begin
            state1 <= SHIFT;
          end else begin
            sh1 <= pad1_buttons;
          end
        end
        SHIFT: begin
          if (strobe_set) begin
            state1 <= LOAD;
            sh1    <= pad1_buttons;
          end else if (acc1) begin
            sh1 <= {1'b1, sh1[7:1]};
          end
        end
        default: state1 <= SHIFT;
      endcase

      unique case (state2)
        LOAD: begin
          if (strobe_clr) begin
            state2 <= SHIFT;
          end else begin
            sh2 <= pad2_buttons;
          end
        end
        SHIFT: begin
          if (strobe_set) begin
            state2 <= LOAD;
            sh2    <= pad2_buttons;
          end else if (acc2) begin
            sh2 <= {1'b1, sh2[7:1]};
          end
        end
        default: state2 <= SHIFT;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_bus_responder.sv
// Directed scoreboard bench for cpu_bus_responder.
// Expected d_in values are queued at drive time and popped after each edge.
module tb_cpu_bus_responder;

  logic        clk;
  logic        rst;
  logic [15:0] addr;
  logic [7:0]  d_out;
  logic        write;
  logic [7:0]  d_in;
  logic [7:0]  pad1_buttons;
  logic [7:0]  pad2_buttons;
  logic [14:0] rom_addr;
  logic [7:0]  rom_data;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q [$];
  string      tag_q [$];

  cpu_bus_responder dut (
    .clk          (clk),
    .rst          (rst),
    .addr         (addr),
    .d_out        (d_out),
    .write        (write),
    .d_in         (d_in),
    .pad1_buttons (pad1_buttons),
    .pad2_buttons (pad2_buttons),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic [15:0] a, input logic w,
                     input logic [7:0] d, input logic chk,
                     input logic [7:0] e, input string tag);
    logic [7:0] ev;
    string      et;
    @(negedge clk);
    addr  = a;
    write = w;
    d_out = d;
    if (chk) begin
      exp_q.push_back(e);
      tag_q.push_back(tag);
    end
    @(posedge clk);
    #1;
    if (chk) begin
      ev = exp_q.pop_front();
      et = tag_q.pop_front();
      check(et, {8'h00, d_in}, {8'h00, ev});
    end
  endtask

  task automatic rd(input logic [15:0] a, input logic [7:0] e,
                    input string tag);
    cyc(a, 1'b0, 8'h00, 1'b1, e, tag);
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d,
                    input string tag);
    cyc(a, 1'b1, d, 1'b1, d, tag);
  endtask

  logic [7:0] seq37 [9];
  logic [7:0] seq38 [6];

  initial begin
    seq37 = '{8'h41, 8'h40, 8'h40, 8'h40, 8'h40,
              8'h40, 8'h40, 8'h41, 8'h41};
    rst          = 1'b1;
    addr         = 16'h0000;
    d_out        = 8'h00;
    write        = 1'b0;
    pad1_buttons = 8'h00;
    pad2_buttons = 8'h00;
    rom_data     = 8'h00;

    #2 rst = 1'b0;
    #1;
    check("reset_d_in", {8'h00, d_in}, 16'h0000);
    check("reset_strobe", {15'h0, dut.strobe}, 16'h0000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    // RAM write then mirrored read
    wr(16'h0005, 8'hA5, "ram_wr_bus");
    rd(16'h0805, 8'hA5, "ram_mirror_rd");
    wr(16'h0000, 8'h77, "ram0_wr");

    // Full 8-bit serial read plus trailing ones
    pad1_buttons = 8'b1000_0001;
    wr(16'h4016, 8'h01, "strobe_hi");
    wr(16'h4016, 8'h00, "strobe_lo");
    for (int i = 0; i < 9; i++) begin
      rd(16'h4016, seq37[i], $sformatf("pad1_bit%0d", i));
      rd(16'h0000, 8'h77, "ram0_sep");
    end

    // Held read shifts only once
    pad1_buttons = 8'b0000_0110;
    wr(16'h4016, 8'h01, "strobe_hi2");
    wr(16'h4016, 8'h00, "strobe_lo2");
    seq38 = '{8'h40, 8'h41, 8'h41, 8'h41, 8'h41, 8'h40};
    rd(16'h4016, seq38[0], "held_c0");
    rd(16'h4016, seq38[1], "held_c1");
    rd(16'h4016, seq38[2], "held_c2");
    rd(16'h0000, 8'h77, "ram0_sep2");
    rd(16'h4016, seq38[3], "after_hold_b1");
    rd(16'h0000, 8'h77, "ram0_sep3");
    rd(16'h4016, seq38[4], "after_hold_b2");
    rd(16'h0000, 8'h77, "ram0_sep4");
    rd(16'h4016, seq38[5], "after_hold_b3");

    // Live bit while strobe is high, both ports
    wr(16'h4016, 8'h01, "strobe_hi3");
    pad1_buttons = 8'h01;
    pad2_buttons = 8'h00;
    rd(16'h4016, 8'h41, "live_pad1_1");
    pad1_buttons = 8'h00;
    rd(16'h0000, 8'h77, "ram0_sep5");
    rd(16'h4016, 8'h40, "live_pad1_0");
    pad2_buttons = 8'b0000_0101;
    rd(16'h4017, 8'h41, "live_pad2_1");
    wr(16'h4016, 8'h00, "strobe_lo3");
    rd(16'h0000, 8'h77, "ram0_sep6");
    rd(16'h4017, 8'h41, "pad2_b0");
    rd(16'h0000, 8'h77, "ram0_sep7");
    rd(16'h4017, 8'h40, "pad2_b1");
    rd(16'h0000, 8'h77, "ram0_sep8");
    rd(16'h4017, 8'h41, "pad2_b2");
    wr(16'h4017, 8'h01, "pad2_wr_bus");
    rd(16'h4017, 8'h40, "pad2_wr_nostrobe");

    // ROM read, ROM write ignored
    rom_data = 8'h5A;
    rd(16'h8123, 8'h5A, "rom_rd");
    check("rom_addr", {1'b0, rom_addr}, 16'h0123);
    wr(16'h8123, 8'h00, "rom_wr_bus");
    rd(16'h8123, 8'h5A, "rom_rd_again");

    // Open bus on unmapped reads
    wr(16'h0010, 8'h3C, "ram10_wr");
    rd(16'h0000, 8'h77, "ram0_sep9");
    rd(16'h0010, 8'h3C, "ram10_rd");
    rd(16'h5000, 8'h3C, "open_bus_5000");
    rd(16'h4015, 8'h3C, "open_bus_4015");
    wr(16'h5000, 8'h99, "unmapped_wr_bus");
    rd(16'h1010, 8'h3C, "ram10_mirror");

    // Reset mid-shift with strobe high
    wr(16'h4016, 8'h01, "strobe_hi4");
    pad1_buttons = 8'h01;
    rd(16'h4016, 8'h41, "live_pre_reset");
    #2 rst = 1'b0;
    #1;
    check("async_rst_d_in", {8'h00, d_in}, 16'h0000);
    check("async_rst_strobe", {15'h0, dut.strobe}, 16'h0000);
    @(negedge clk);
    rst = 1'b1;
    pad1_buttons = 8'h00;
    rd(16'h4016, 8'h41, "post_rst_pad1");
    rd(16'h4017, 8'h41, "post_rst_pad2");
    rd(16'h0005, 8'hA5, "ram_kept_rst");

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
